// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: operator-group codes, instruction-field constants and the
// decoded-field record shared by the decode queue and the trace monitor.
package decode_queue_pkg;

    typedef enum logic [3:0] {
        GROUP_CRVMATH       = 4'd0,
        GROUP_RJMP          = 4'd1,
        GROUP_CRRMATH       = 4'd2,
        GROUP_CRSMATH       = 4'd3,
        GROUP_WRRMATH       = 4'd4,
        GROUP_WRRMATH_MEM   = 4'd5,
        GROUP_WRSMATH       = 4'd6,
        GROUP_WRSMATH_STACK = 4'd7,
        GROUP_SFLAG         = 4'd8,
        GROUP_UFLAG         = 4'd9,
        GROUP_SPECIAL       = 4'd10,
        GROUP_ILLEGAL       = 4'd15
    } group_e;

    // Operator nibble that turns a SPECIAL word into a two-word instruction.
    localparam logic [3:0] EXT_OPERATOR    = 4'hF;
    // Low five bits identifying the SPECIAL group.
    localparam logic [4:0] SPECIAL_PATTERN = 5'b11011;

    typedef struct packed {
        group_e      grp;
        logic [3:0]  opr;
        logic [2:0]  rgv;
        logic [2:0]  rg1;
        logic [2:0]  rg2;
        logic [7:0]  val;
        logic [9:0]  rel_addr;
        logic        illegal;
    } insn_fields_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side push handshake, flush, execute-side decoded
// instruction handshake and occupancy level.
//   master : fetch/execute side (drives flush, in_valid, in_word, out_ready)
//   slave  : the decode queue
interface decode_queue_if #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_group;
    logic [3:0]        out_operator;
    logic [2:0]        out_rgv;
    logic [2:0]        out_rg1;
    logic [2:0]        out_rg2;
    logic [7:0]        out_val;
    logic [9:0]        out_rel_addr;
    logic              out_has_imm;
    logic [WORD_W-1:0] out_imm;
    logic              out_illegal;
    logic [LVL_W-1:0]  level;

    modport master (
        output flush, in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_group, out_operator, out_rgv, out_rg1,
               out_rg2, out_val, out_rel_addr, out_has_imm, out_imm,
               out_illegal, level
    );

    modport slave (
        input  flush, in_valid, in_word, out_ready,
        output in_ready, out_valid, out_group, out_operator, out_rgv, out_rg1,
               out_rg2, out_val, out_rel_addr, out_has_imm, out_imm,
               out_illegal, level
    );
endinterface

// File: rtl/decode_queue_insn_field_decode.sv
// insn_field_decode: purely combinational decode of one 16-bit instruction
// word into operator group, register/value fields, illegal flag and the
// "first word of an extended instruction" flag.
//   word   in   instruction word
//   fields out  decoded group and fields
//   is_ext out  word is the first half of a two-word instruction
module insn_field_decode
    import decode_queue_pkg::*;
#(
    parameter int EXT_ENABLE = 1
) (
    input  logic [15:0]  word,
    output insn_fields_t fields,
    output logic         is_ext
);

    always_comb begin
        fields          = '0;
        fields.grp      = GROUP_CRVMATH;
        fields.opr      = word[15:12];
        fields.rgv      = word[3:1];
        fields.rg1      = word[7:5];
        fields.rg2      = word[10:8];
        fields.val      = word[11:4];
        fields.rel_addr = {2'b00, word[7:0]};
        fields.illegal  = 1'b0;
        casez (word[4:0])
            5'b0????: fields.grp = GROUP_CRVMATH;
            5'b10???: fields.grp = GROUP_RJMP;
            5'b11100: fields.grp = GROUP_CRRMATH;
            5'b11110: fields.grp = GROUP_CRSMATH;
            5'b11101: begin
                // 1011 and 1111 are register forms despite the top bit set.
                if (word[15:12] == 4'b1011 || word[15:12] == 4'b1111)
                    fields.grp = GROUP_WRRMATH;
                else if (word[15])
                    fields.grp = GROUP_WRRMATH_MEM;
                else
                    fields.grp = GROUP_WRRMATH;
            end
            5'b11111: fields.grp = (word[15:13] == 3'b111) ? GROUP_WRSMATH_STACK
                                                            : GROUP_WRSMATH;
            5'b11000: fields.grp = GROUP_SFLAG;
            5'b11001: fields.grp = GROUP_UFLAG;
            SPECIAL_PATTERN: fields.grp = GROUP_SPECIAL;
            default: begin
                fields.grp     = GROUP_ILLEGAL;
                fields.illegal = 1'b1;
            end
        endcase
    end

    assign is_ext = (EXT_ENABLE != 0) && (word[4:0] == SPECIAL_PATTERN) &&
                    (word[15:12] == EXT_OPERATOR);

endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction-word queue between fetch and execute.
// The head entry is decoded combinationally; an extended head also presents
// the following entry as its immediate and is only offered once both words
// are queued, then consumed as a unit.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : decode_queue_if slave (push side, flush, decoded output, level)
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int DEPTH      = 4,
    parameter int EXT_ENABLE = 1
) (
    input logic          clk,
    input logic          reset,
    decode_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic [WORD_W-1:0] head_word;
    logic [WORD_W-1:0] next_word;
    insn_fields_t      head_f;
    logic              head_ext;
    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;

    // Pointer arithmetic wraps for free because DEPTH is a power of two.
    assign head_word = mem_q[rd_ptr_q];
    assign next_word = mem_q[rd_ptr_q + PTR_W'(1)];

    insn_field_decode #(.EXT_ENABLE(EXT_ENABLE)) u_head_decode (
        .word   (head_word[15:0]),
        .fields (head_f),
        .is_ext (head_ext)
    );

    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = head_ext ? (level_q >= LVL_W'(2)) : (level_q != LVL_W'(0));
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.in_word;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + (head_ext ? PTR_W'(2) : PTR_W'(1));
            level_d = level_q + LVL_W'(push)
                    - (pop ? (head_ext ? LVL_W'(2) : LVL_W'(1)) : LVL_W'(0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_group    = head_f.grp;
    assign bus.out_operator = head_f.opr;
    assign bus.out_rgv      = head_f.rgv;
    assign bus.out_rg1      = head_f.rg1;
    assign bus.out_rg2      = head_f.rg2;
    assign bus.out_val      = head_f.val;
    assign bus.out_rel_addr = head_f.rel_addr;
    assign bus.out_has_imm  = head_ext;
    assign bus.out_imm      = head_ext ? next_word : '0;
    assign bus.out_illegal  = head_f.illegal;
    assign bus.level        = level_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (extended decode on and off) share
// one stimulus stream; a monitor checks each consumed instruction against
// hand-written expectations queued per instance.
module tb_decode_queue;
    import decode_queue_pkg::*;

    typedef struct packed {
        logic [3:0]  grp;
        logic [3:0]  opr;
        logic [2:0]  rgv;
        logic [2:0]  rg1;
        logic [2:0]  rg2;
        logic [7:0]  val;
        logic [9:0]  rel;
        logic        has_imm;
        logic [15:0] imm;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    decode_queue_if #(.WORD_W(16), .DEPTH(4)) if0 ();
    decode_queue_if #(.WORD_W(16), .DEPTH(4)) if1 ();

    decode_queue #(.WORD_W(16), .DEPTH(4), .EXT_ENABLE(1)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    decode_queue #(.WORD_W(16), .DEPTH(4), .EXT_ENABLE(0)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    assign if1.flush     = if0.flush;
    assign if1.in_valid  = if0.in_valid;
    assign if1.in_word   = if0.in_word;
    assign if1.out_ready = if0.out_ready;

    // Fields are plain bit slices of the word; group/imm/illegal are hand-given.
    function automatic exp_t mk(input logic [15:0] w, input logic [3:0] g,
                                input logic hi, input logic [15:0] imm);
        exp_t e;
        e.grp = g; e.opr = w[15:12]; e.rgv = w[3:1]; e.rg1 = w[7:5];
        e.rg2 = w[10:8]; e.val = w[11:4]; e.rel = {2'b00, w[7:0]};
        e.has_imm = hi; e.imm = imm; e.ill = (g == 4'(GROUP_ILLEGAL));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: compares the presented instruction whenever it is consumed.
    initial begin
        exp_t a;
        forever begin
            @(negedge clk);
            if (!reset && if0.out_valid && if0.out_ready) begin
                a = {if0.out_group, if0.out_operator, if0.out_rgv, if0.out_rg1,
                     if0.out_rg2, if0.out_val, if0.out_rel_addr, if0.out_has_imm,
                     if0.out_imm, if0.out_illegal};
                if (q0.size() == 0) begin
                    total++;
                    $display("FAIL ext_pop_unexpected: got 0x%0h expected none", a);
                end else chk("ext_pop", 64'(a), 64'(q0.pop_front()));
            end
            if (!reset && if1.out_valid && if1.out_ready) begin
                a = {if1.out_group, if1.out_operator, if1.out_rgv, if1.out_rg1,
                     if1.out_rg2, if1.out_val, if1.out_rel_addr, if1.out_has_imm,
                     if1.out_imm, if1.out_illegal};
                if (q1.size() == 0) begin
                    total++;
                    $display("FAIL noext_pop_unexpected: got 0x%0h expected none", a);
                end else chk("noext_pop", 64'(a), 64'(q1.pop_front()));
            end
        end
    end

    // One clock cycle of stimulus; an accepted word queues its expectation
    // for both instances when auto is set.
    task automatic cyc(input logic v, input logic [15:0] w, input logic rdy,
                       input logic [3:0] g, input logic auto);
        if0.in_valid  = v;
        if0.in_word   = w;
        if0.out_ready = rdy;
        @(negedge clk);
        if (v && if0.in_ready && auto && !if0.flush) begin
            q0.push_back(mk(w, g, 1'b0, 16'h0));
            q1.push_back(mk(w, g, 1'b0, 16'h0));
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sw [13];
    logic [3:0]  sg [13];

    initial begin
        int idx;
        logic acc;
        sw[0]  = 16'h1100; sg[0]  = GROUP_CRVMATH;
        sw[1]  = 16'h2211; sg[1]  = GROUP_RJMP;
        sw[2]  = 16'h331C; sg[2]  = GROUP_CRRMATH;
        sw[3]  = 16'h441E; sg[3]  = GROUP_CRSMATH;
        sw[4]  = 16'h5518; sg[4]  = GROUP_SFLAG;
        sw[5]  = 16'h6619; sg[5]  = GROUP_UFLAG;
        sw[6]  = 16'hB01D; sg[6]  = GROUP_WRRMATH;
        sw[7]  = 16'h901D; sg[7]  = GROUP_WRRMATH_MEM;
        sw[8]  = 16'hE01F; sg[8]  = GROUP_WRSMATH_STACK;
        sw[9]  = 16'h201F; sg[9]  = GROUP_WRSMATH;
        sw[10] = 16'h401D; sg[10] = GROUP_WRRMATH;
        sw[11] = 16'hF01D; sg[11] = GROUP_WRRMATH;
        sw[12] = 16'h701B; sg[12] = GROUP_SPECIAL;

        reset = 1'b1;
        if0.flush = 1'b0; if0.in_valid = 1'b0; if0.in_word = '0; if0.out_ready = 1'b0;
        #12;
        chk("rst_level",    64'(if0.level),       64'd0);
        chk("rst_in_ready", 64'(if0.in_ready),    64'd1);
        chk("rst_valid",    64'(if0.out_valid),   64'd0);
        chk("rst_group",    64'(if0.out_group),   64'(GROUP_CRVMATH));
        chk("rst_has_imm",  64'(if0.out_has_imm), 64'd0);
        chk("rst_illegal",  64'(if0.out_illegal), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Basic push/pop ordering.
        cyc(1'b1, 16'h0000, 1'b0, GROUP_CRVMATH, 1'b1);
        chk("first_valid", 64'(if0.out_valid), 64'd1);
        chk("lvl_a1", 64'(if0.level), 64'd1);
        cyc(1'b1, 16'h1234, 1'b0, GROUP_RJMP, 1'b1);
        chk("lvl_a2", 64'(if0.level), 64'd2);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("lvl_a3", 64'(if0.level), 64'd1);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("lvl_a4", 64'(if0.level), 64'd0);
        chk("empty_valid", 64'(if0.out_valid), 64'd0);

        // Field decode.
        cyc(1'b1, 16'h3A3C, 1'b0, GROUP_CRRMATH, 1'b1);
        chk("crr_rg2", 64'(if0.out_rg2), 64'd2);
        cyc(1'b1, 16'h0010, 1'b0, GROUP_RJMP, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("lvl_b", 64'(if0.level), 64'd0);

        // Extended instruction with a fetch stall between its two words.
        q0.push_back(mk(16'hF01B, GROUP_SPECIAL, 1'b1, 16'hBEEF));
        q1.push_back(mk(16'hF01B, GROUP_SPECIAL, 1'b0, 16'h0));
        q1.push_back(mk(16'hBEEF, GROUP_CRVMATH, 1'b0, 16'h0));
        cyc(1'b1, 16'hF01B, 1'b1, 4'd0, 1'b0);
        chk("ext_wait_valid1", 64'(if0.out_valid), 64'd0);
        chk("ext_wait_lvl1",   64'(if0.level),     64'd1);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("ext_wait_valid2", 64'(if0.out_valid), 64'd0);
        chk("ext_wait_lvl2",   64'(if0.level),     64'd1);
        cyc(1'b1, 16'hBEEF, 1'b1, 4'd0, 1'b0);
        chk("ext_ready_valid", 64'(if0.out_valid), 64'd1);
        chk("ext_ready_lvl",   64'(if0.level),     64'd2);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("ext_done_lvl",    64'(if0.level),     64'd0);
        chk("noext_done_lvl",  64'(if1.level),     64'd0);

        // Fill to DEPTH, then stream with pointer wrap.
        for (int i = 0; i < 4; i++) cyc(1'b1, sw[i], 1'b0, sg[i], 1'b1);
        chk("full_lvl",      64'(if0.level),    64'd4);
        chk("full_in_ready", 64'(if0.in_ready), 64'd0);
        cyc(1'b1, sw[4], 1'b0, sg[4], 1'b1);
        chk("full_hold_lvl", 64'(if0.level),    64'd4);
        idx = 4;
        for (int n = 0; n < 40 && idx < 13; n++) begin
            acc = if0.in_ready;
            cyc(1'b1, sw[idx], 1'b1, sg[idx], 1'b1);
            if (acc) idx++;
        end
        chk("stream_all_pushed", 64'(idx), 64'd13);
        for (int n = 0; n < 10 && if0.level != 0; n++) cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("stream_drained", 64'(if0.level), 64'd0);

        // Illegal word is presented and consumed normally.
        cyc(1'b1, 16'h001A, 1'b0, GROUP_ILLEGAL, 1'b1);
        chk("ill_flag",  64'(if0.out_illegal), 64'd1);
        chk("ill_valid", 64'(if0.out_valid),   64'd1);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("ill_lvl", 64'(if0.level), 64'd0);

        // Flush beats a same-cycle push.
        cyc(1'b1, 16'h0001, 1'b0, GROUP_CRVMATH, 1'b1);
        if0.flush = 1'b1;
        cyc(1'b1, 16'h0002, 1'b0, 4'd0, 1'b0);
        if0.flush = 1'b0;
        q0.delete(); q1.delete();
        chk("flush_lvl",   64'(if0.level),     64'd0);
        chk("flush_valid", 64'(if0.out_valid), 64'd0);
        cyc(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
        chk("flush_lvl2",  64'(if0.level),     64'd0);

        // Asynchronous reset mid-stream.
        cyc(1'b1, 16'h0003, 1'b0, GROUP_CRVMATH, 1'b1);
        cyc(1'b1, 16'h0004, 1'b0, GROUP_CRVMATH, 1'b1);
        chk("pre_rst_lvl", 64'(if0.level), 64'd2);
        if0.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(if0.out_valid), 64'd0);
        chk("async_rst_lvl",   64'(if0.level),     64'd0);
        q0.delete(); q1.delete();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        cyc(1'b1, 16'h0005, 1'b0, GROUP_CRVMATH, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
        chk("recover_lvl", 64'(if0.level), 64'd0);

        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
